// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS datapath: next-PC select codes,
// instruction field positions and the immediate sign-extension helper.
package mips_pkg;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_RSVD   = 2'b11;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

    function automatic logic [31:0] sign_ext16(input logic [15:0] val);
        return {{16{val[15]}}, val};
    endfunction

endpackage

// File: rtl/flopenr.sv
// Enabled register with asynchronous active-high reset; width and reset
// value set per instance.
module flopenr #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/datapath_state_unit.sv
// State-holding half of the multicycle MIPS datapath: PC, IR, MDR, A/B and
// ALUOut registers, next-PC select, address mux and instruction decode taps.
module datapath_state_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        branch,
    input  logic        ir_write,
    input  logic        i_or_d,
    input  logic [1:0]  pc_src,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    output logic [31:0] mem_addr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] imm_sext,
    output logic [31:0] jump_target,
    output logic [31:0] pc,
    output logic [31:0] a_q,
    output logic [31:0] b_q,
    output logic [31:0] alu_out,
    output logic [31:0] mdr,
    output logic [31:0] instr_count
);

    logic        w_pc_en;
    logic        w_pc_ld;
    logic [31:0] w_pc_sel;
    logic [31:0] w_pc_d;
    logic [31:0] w_ir;

    logic [31:0] r_mdr;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_alu_out;
    logic [31:0] r_instr_count;

    assign w_pc_en = pc_write | (branch & zero);
    // The reserved select code blocks the PC update even on a taken branch.
    assign w_pc_ld = w_pc_en && (pc_src != PC_SRC_RSVD);

    always_comb begin
        w_pc_sel = pc;
        case (pc_src)
            PC_SRC_ALU:    w_pc_sel = alu_result;
            PC_SRC_ALUOUT: w_pc_sel = r_alu_out;
            PC_SRC_JUMP:   w_pc_sel = jump_target;
            default:       w_pc_sel = pc;
        endcase
    end

    assign w_pc_d = {w_pc_sel[31:2], 2'b00};

    flopenr #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (w_pc_ld),
        .d     (w_pc_d),
        .q     (pc)
    );

    flopenr #(.WIDTH(32), .RESET_VAL(32'h0000_0000)) u_ir_reg (
        .clk   (clk),
        .reset (reset),
        .en    (ir_write),
        .d     (mem_rdata),
        .q     (w_ir)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mdr         <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_alu_out     <= '0;
            r_instr_count <= '0;
        end else begin
            r_mdr     <= mem_rdata;
            r_a       <= rd1;
            r_b       <= rd2;
            r_alu_out <= alu_result;
            if (ir_write) begin
                r_instr_count <= r_instr_count + 32'd1;
            end
        end
    end

    assign mdr         = r_mdr;
    assign a_q         = r_a;
    assign b_q         = r_b;
    assign alu_out     = r_alu_out;
    assign instr_count = r_instr_count;

    assign mem_addr    = i_or_d ? r_alu_out : pc;

    assign opcode      = w_ir[OPCODE_MSB:OPCODE_LSB];
    assign rs          = w_ir[RS_MSB:RS_LSB];
    assign rt          = w_ir[RT_MSB:RT_LSB];
    assign rd          = w_ir[RD_MSB:RD_LSB];
    assign funct       = w_ir[FUNCT_MSB:FUNCT_LSB];
    assign imm_sext    = sign_ext16(w_ir[IMM_MSB:IMM_LSB]);
    assign jump_target = {pc[31:28], w_ir[TARGET_MSB:TARGET_LSB], 2'b00};

endmodule
